// File: rtl/rv_pkg.sv
// Shared core definitions: data width, fetch queue entry layout and queue states.
package rv_pkg;

  localparam int WIDTH_DATA  = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [WIDTH_DATA-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [WIDTH_DATA-1:0] pc;
    logic [WIDTH_DATA-1:0] instruction;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } queue_state_e;

  function automatic logic [WIDTH_DATA-1:0] word_align(input logic [WIDTH_DATA-1:0] addr);
    return addr & ~(WIDTH_DATA'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit bus: instruction memory port, redirect input and the decode handshake.
interface instruction_fetch_if;
  import rv_pkg::*;

  logic [WIDTH_DATA-1:0] imem_addr_o;
  logic [WIDTH_DATA-1:0] imem_instruction_i;
  logic                  redirect_i;
  logic [WIDTH_DATA-1:0] redirect_pc_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [WIDTH_DATA-1:0] instruction_o;
  logic [WIDTH_DATA-1:0] pc_o;

  modport master (
    output imem_addr_o,
    input  imem_instruction_i,
    input  redirect_i,
    input  redirect_pc_i,
    output valid_o,
    input  ready_i,
    output instruction_o,
    output pc_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_instruction_i,
    output redirect_i,
    output redirect_pc_i,
    input  valid_o,
    output ready_i,
    input  instruction_o,
    input  pc_o
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry shifting FIFO of {pc, instruction}; slot0 is always the head so the
// head outputs keep their last value once the queue drains or is flushed.
module fetch_queue
  import rv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  queue_state_e state_q, state_d;
  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic         do_pop_s;
  logic         do_push_s;

  always_comb begin
    do_pop_s  = pop_i && (state_q != Q_EMPTY);
    do_push_s = push_i && ((state_q != Q_FULL) || do_pop_s);
  end

  // Occupancy FSM and slot shifting; flush overrides any push/pop that cycle.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush_i) begin
      state_d = Q_EMPTY;
    end else begin
      case (state_q)
        Q_EMPTY: begin
          if (do_push_s) begin
            slot0_d = entry_i;
            state_d = Q_ONE;
          end else begin
            state_d = Q_EMPTY;
          end
        end
        Q_ONE: begin
          if (do_push_s && do_pop_s) begin
            slot0_d = entry_i;
          end else if (do_push_s) begin
            slot1_d = entry_i;
            state_d = Q_FULL;
          end else if (do_pop_s) begin
            state_d = Q_EMPTY;
          end else begin
            state_d = Q_ONE;
          end
        end
        Q_FULL: begin
          if (do_pop_s) begin
            slot0_d = slot1_q;
            if (do_push_s) begin
              slot1_d = entry_i;
            end else begin
              state_d = Q_ONE;
            end
          end else begin
            state_d = Q_FULL;
          end
        end
        default: begin
          state_d = Q_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Q_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign head_o  = slot0_q;
  assign full_o  = (state_q == Q_FULL);
  assign empty_o = (state_q == Q_EMPTY);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per cycle when the queue
// has room, and restarts at a word-aligned target on redirect.
module instruction_fetch
  import rv_pkg::*;
#(
  parameter logic [WIDTH_DATA-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  instruction_fetch_if.master bus_if
);

  logic [WIDTH_DATA-1:0] pc_q, pc_d;
  logic                  full_s;
  logic                  empty_s;
  logic                  pop_s;
  logic                  fetch_s;
  logic                  push_s;
  fetch_entry_t          entry_s;
  fetch_entry_t          head_s;

  // A pop frees a slot in the same cycle, so a full queue still fetches when decode accepts.
  always_comb begin
    pop_s               = !empty_s && bus_if.ready_i;
    fetch_s             = !full_s || pop_s;
    push_s              = fetch_s && !bus_if.redirect_i;
    entry_s.pc          = pc_q;
    entry_s.instruction = bus_if.imem_instruction_i;
  end

  always_comb begin
    if (bus_if.redirect_i) begin
      pc_d = word_align(bus_if.redirect_pc_i);
    end else if (fetch_s) begin
      pc_d = pc_q + WIDTH_DATA'(INSTR_BYTES);
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (bus_if.redirect_i),
    .entry_i (entry_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign bus_if.imem_addr_o   = pc_q;
  assign bus_if.valid_o       = !empty_s;
  assign bus_if.instruction_o = head_s.instruction;
  assign bus_if.pc_o          = head_s.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a queue-based reference model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_000C: return 32'h0000_0013;
      32'h0000_0040: return 32'h0000_006F;
      default:       return {a[15:0], ~a[31:16]};
    endcase
  endfunction

  assign bus.imem_instruction_i = mem_word(bus.imem_addr_o);

  // Reference model: a plain queue of fetched entries plus the fetch PC.
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] last_pc;
  logic [31:0] last_ins;
  logic [96:0] got;
  logic [96:0] want;

  function automatic logic [96:0] expected();
    return {mq.size() != 0, last_pc, last_ins, m_pc};
  endfunction

  function automatic logic [96:0] observed();
    return {bus.valid_o, bus.pc_o, bus.instruction_o, bus.imem_addr_o};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc     = RESET_PC;
    last_pc  = 32'h0;
    last_ins = 32'h0;
  endtask

  task automatic model_edge(input logic rdr, input logic [31:0] rpc, input logic rdy);
    bit pop;
    bit fetch;
    pop   = (mq.size() != 0) && rdy;
    fetch = (mq.size() < 2) || pop;
    if (rdr) begin
      mq.delete();
      m_pc = rpc & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (fetch) begin
        mq.push_back('{m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    if (mq.size() != 0) begin
      last_pc  = mq[0].pc;
      last_ins = mq[0].ins;
    end
  endtask

  // Called at a falling edge: drive inputs, advance one cycle, return at the next falling edge.
  task automatic tick(input logic rdr, input logic [31:0] rpc, input logic rdy);
    bus.redirect_i    = rdr;
    bus.redirect_pc_i = rpc;
    bus.ready_i       = rdy;
    @(posedge clk);
    model_edge(rdr, rpc, rdy);
    @(negedge clk);
  endtask

  task automatic release_reset();
    bus.redirect_i = 1'b0;
    bus.ready_i    = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    got  = observed();
    want = {1'b0, 32'h0, 32'h0, RESET_PC};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_values got %h expected %h", got, want);
    end
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_stream();
    release_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick(1'b0, 32'h0, 1'b1);
      got = observed(); want = expected(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stream[%0d] got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_backpressure();
    release_reset();
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 32'h0, (i >= 5));
      got = observed(); want = expected(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL backpressure[%0d] got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_redirect_full();
    release_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3)       tick(1'b0, 32'h0, 1'b0);
      else if (i == 3) tick(1'b1, 32'h0000_0042, 1'b0);
      else             tick(1'b0, 32'h0, 1'b1);
      got = observed(); want = expected(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL redirect_full[%0d] got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_redirect_handshake();
    logic [31:0] tgt;
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL handshake_pre_valid got %b expected 1", bus.valid_o);
    end
    tgt = $urandom & 32'h0000_FFFC;
    for (int i = 0; i < 4; i++) begin
      tick((i == 0), tgt, 1'b1);
      got = observed(); want = expected(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL redirect_handshake[%0d] got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    got  = observed();
    want = {1'b0, 32'h0, 32'h0, RESET_PC};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", got, want);
    end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 1'b1);
      got = observed(); want = expected(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL after_reset[%0d] got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      tick((i == 0), 32'hFFFF_FFFE, 1'b1);
      got = observed(); want = expected(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap[%0d] got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      tick((i < 4), $urandom, 1'($urandom_range(0, 1)));
      got = observed(); want = expected(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) == 0), $urandom, 1'($urandom_range(0, 1)));
      got = observed(); want = expected(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random[%0d] got %h expected %h", i, got, want);
      end
    end
  endtask

  initial begin
    clk               = 1'b0;
    rst               = 1'b1;
    checks            = 0;
    errors            = 0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.ready_i       = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_handshake();
    test_async_reset();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
